// File: rtl/seg7_display_sched.sv
// Round-robin scheduler feeding a 5-digit BCD seven-segment display; values are converted by a
// sequential double-dabble engine. Define SEG7_DISPLAY_SCHED_BLANK_EN to blank leading zeros.
module seg7_display_sched #(
  parameter int NREQ         = 4,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      ack,
  output logic [19:0]          bcd_out,
  output logic                 bcd_valid,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DWELL   = 2'd2;
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [1:0]      state_reg;
  logic [2:0]      last_reg;
  logic [2:0]      grant_reg;
  logic [15:0]     shift_reg;
  logic [19:0]     scratch_reg;
  logic [3:0]      iter_reg;
  logic [CW-1:0]   dwell_reg;
  logic [NREQ-1:0] ack_reg;
  logic [19:0]     bcd_reg;
  logic            valid_reg;

  logic            win_found;
  logic [2:0]      win_idx;
  logic [15:0]     win_data;
  logic [19:0]     adj;
  logic [19:0]     scratch_next;
  logic [19:0]     final_bcd;
  logic            unused_top;

  function automatic int rr_idx(input logic [2:0] l, input int off);
    return (int'(l) + off) % NREQ;
  endfunction

  // Scan from the farthest offset down so the nearest set bit after last wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_data  = 16'd0;
    for (int off = NREQ; off >= 1; off--) begin
      if (req[rr_idx(last_reg, off)]) begin
        win_found = 1'b1;
        win_idx   = 3'(rr_idx(last_reg, off));
        win_data  = data[16*rr_idx(last_reg, off) +: 16];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_add3
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              scratch_reg[gi*4 +: 4] + 4'd3 : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  // The top scratch bit falls off the shift; it is always zero for 16-bit inputs.
  assign scratch_next = {adj[18:0], shift_reg[15]};
  assign unused_top   = adj[19];

`ifdef SEG7_DISPLAY_SCHED_BLANK_EN
  function automatic logic [19:0] blank_lead(input logic [19:0] b);
    logic [19:0] r;
    logic        lead;
    r    = b;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (b[i*4 +: 4] == 4'd0)) r[i*4 +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction

  assign final_bcd = blank_lead(scratch_next);
`else
  assign final_bcd = scratch_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= 3'(NREQ - 1);
      grant_reg   <= 3'd0;
      shift_reg   <= 16'd0;
      scratch_reg <= 20'd0;
      iter_reg    <= 4'd0;
      dwell_reg   <= '0;
      ack_reg     <= '0;
      bcd_reg     <= 20'h00000;
      valid_reg   <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            shift_reg   <= win_data;
            scratch_reg <= 20'd0;
            iter_reg    <= 4'd0;
            grant_reg   <= win_idx;
            last_reg    <= win_idx;
            ack_reg     <= NREQ'(1) << win_idx;
            state_reg   <= CONVERT;
          end
        end
        CONVERT: begin
          scratch_reg <= scratch_next;
          shift_reg   <= {shift_reg[14:0], 1'b0};
          iter_reg    <= iter_reg + 4'd1;
          if (iter_reg == 4'd15) begin
            bcd_reg   <= final_bcd;
            valid_reg <= 1'b1;
            dwell_reg <= CW'(DWELL_CYCLES - 1);
            state_reg <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_reg == '0) state_reg <= IDLE;
          else                 dwell_reg <= dwell_reg - 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack       = ack_reg;
  assign bcd_out   = bcd_reg;
  assign bcd_valid = valid_reg;
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_reg;

endmodule

// File: tb/tb_seg7_display_sched.sv
// Self-checking bench for seg7_display_sched: directed table, hand-written corner sequences and
// randomized requests checked against an arithmetic decimal / round-robin reference model.
module tb_seg7_display_sched;
  localparam int NREQ = 4;
  localparam int DW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic [19:0]       bcd_out;
  logic              bcd_valid;
  logic              busy;
  logic [2:0]        grant_id;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int last_m;

  seg7_display_sched #(.NREQ(NREQ), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    int          didx;
    logic [15:0] val;
    int          exp_id;
    logic [19:0] exp_bcd;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Decimal digits by division, then optional leading-zero blanking.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int          p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef SEG7_DISPLAY_SCHED_BLANK_EN
    for (int i = 4; i >= 1; i--) begin
      if (r[i*4 +: 4] != 4'd0) break;
      r[i*4 +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  function automatic int model_winner(input int l, input logic [3:0] m);
    for (int off = 1; off <= NREQ; off++)
      if (m[(l + off) % NREQ]) return (l + off) % NREQ;
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [15:0] v);
    data[16*i +: 16] = v;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (ack == '0 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (ack == '0) check("ack_timeout", 32'(ack), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    last_m = NREQ - 1;
  endtask

  task automatic do_txn(input string name, input logic [3:0] mask, input logic keep,
                        input int exp_id, input logic [19:0] exp_bcd, input int exp_wc);
    int          cyc;
    logic [19:0] prev;
    req = mask;
    wait_ack(cyc);
    check({name, "_ack"}, 32'(ack), 32'(1) << exp_id);
    check({name, "_wait"}, 32'(cyc), 32'(exp_wc));
    check({name, "_grant"}, 32'(grant_id), 32'(exp_id));
    check({name, "_busy"}, 32'(busy), 32'(1));
    if (!keep) req = '0;
    prev = bcd_out;
    tick();
    check({name, "_ackpulse"}, 32'(ack), 32'(0));
    repeat (14) tick();
    check({name, "_hold"}, 32'(bcd_out), 32'(prev));
    tick();
    check({name, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    check({name, "_valid"}, 32'(bcd_valid), 32'(1));
    check({name, "_busy2"}, 32'(busy), 32'(1));
    $display("txn %s id=%0d bcd=%05h wait=%0d", name, grant_id, bcd_out, cyc);
    last_m = exp_id;
  endtask

  initial begin
    int          cyc;
    int          nacks;
    int          w;
    logic [3:0]  m;
    logic [19:0] prev;

    rst  = 1'b1;
    req  = '0;
    data = '0;
    do_reset();
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_bcd", 32'(bcd_out), 32'(0));
    check("rst_valid", 32'(bcd_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant", 32'(grant_id), 32'(0));

    tbl[0] = '{4'b0001, 0, 16'd65535, 0, 20'h65535};
    tbl[4] = '{4'b1000, 3, 16'd10000, 3, 20'h10000};
`ifdef SEG7_DISPLAY_SCHED_BLANK_EN
    tbl[1] = '{4'b0010, 1, 16'd0,     1, 20'hFFFF0};
    tbl[2] = '{4'b0010, 1, 16'd1234,  1, 20'hF1234};
    tbl[3] = '{4'b0100, 2, 16'd42,    2, 20'hFFF42};
    tbl[5] = '{4'b0001, 0, 16'd9999,  0, 20'hF9999};
`else
    tbl[1] = '{4'b0010, 1, 16'd0,     1, 20'h00000};
    tbl[2] = '{4'b0010, 1, 16'd1234,  1, 20'h01234};
    tbl[3] = '{4'b0100, 2, 16'd42,    2, 20'h00042};
    tbl[5] = '{4'b0001, 0, 16'd9999,  0, 20'h09999};
`endif
    for (int i = 0; i < 6; i++) begin
      set_data(tbl[i].didx, tbl[i].val);
      do_txn($sformatf("tbl%0d", i), tbl[i].mask, 1'b0, tbl[i].exp_id, tbl[i].exp_bcd,
             (i == 0) ? 1 : DW + 1);
    end

    // Requests raised while busy must wait until the block is idle again.
    set_data(0, 16'd123);
    set_data(2, 16'd4567);
    req = 4'b0001;
    wait_ack(cyc);
    check("busyreq_first_ack", 32'(ack), 32'(1));
    req = 4'b0100;
    prev = bcd_out;
    nacks = 0;
    for (int c = 1; c <= 16 + DW; c++) begin
      tick();
      if (ack != '0) nacks++;
      if (c == 15) check("busyreq_hold", 32'(bcd_out), 32'(prev));
    end
    check("busyreq_noack", 32'(nacks), 32'(0));
    check("busyreq_bcd1", 32'(bcd_out), 32'(ref_bcd(123)));
    tick();
    check("busyreq_second_ack", 32'(ack), 32'(4'b0100));
    req = '0;
    repeat (16) tick();
    check("busyreq_bcd2", 32'(bcd_out), 32'(ref_bcd(4567)));
    $display("txn busyreq id=%0d bcd=%05h", grant_id, bcd_out);
    last_m = 2;

    // Reset in the middle of a conversion discards it entirely.
    set_data(3, 16'd9999);
    req = 4'b1000;
    wait_ack(cyc);
    check("abort_ack", 32'(ack), 32'(4'b1000));
    req = '0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_m = NREQ - 1;
    check("abort_ack0", 32'(ack), 32'(0));
    check("abort_bcd", 32'(bcd_out), 32'(0));
    check("abort_valid", 32'(bcd_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_grant", 32'(grant_id), 32'(0));
    set_data(0, 16'd9999);
    do_txn("after_abort", 4'b0001, 1'b0, 0, ref_bcd(9999), 1);

    // All requesters held high: strict round-robin from requester 0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, 16'(i * 1000 + i));
    for (int g = 0; g < 5; g++)
      do_txn($sformatf("rr%0d", g), 4'b1111, 1'b1, g % NREQ, ref_bcd((g % NREQ) * 1001),
             (g == 0) ? 1 : DW + 1);
    req = '0;

    // Randomized masks and values.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NREQ; i++) set_data(i, 16'($urandom_range(0, 65535)));
      m = 4'($urandom_range(1, 15));
      w = model_winner(last_m, m);
      do_txn($sformatf("rnd%0d", r), m, 1'b0, w, ref_bcd(int'(data[16*w +: 16])), DW + 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
